fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side stream adapter for the asynchronous FIFO, in the rclk domain directly downstream of the read-pointer/empty logic and the FIFO storage. It turns the FIFO's `empty`/`rinc` pop interface into a registered valid/ready stream. A 2-entry output buffer gives full throughput. `rinc` never depends combinationally on downstream `m_ready`.

## Interface
- DATA_WIDTH, default 8: width of FIFO words and stream data.
- CNT_WIDTH, default 16: width of the beat counter (used only with the stats feature).

Ports:
- rclk  in  1  read-domain clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  registered empty flag from the read-pointer stage.
- fifo_rdata  in  DATA_WIDTH  head-of-FIFO word; valid in any cycle where fifo_empty=0.
- rinc  out  1  pop request to the read-pointer stage.
- m_valid  out  1  stream data valid (registered).
- m_data  out  DATA_WIDTH  stream data (registered).
- m_ready  in  1  downstream accepts the beat when m_valid=1.
- level  out  2  buffer occupancy, 0..2 (registered).
- beat_cnt  out  CNT_WIDTH  count of accepted beats; 0 when the stats feature is compiled out.

## Operation
- Storage:
  - main register drives m_data.
  - skid register holds a second word.
  - state is one of EMPTY(0), ONE(1), TWO(2); level equals state.
- Fetch and pop:
  - rinc = ~fifo_empty & (state != TWO), combinational from state and fifo_empty only.
  - push = rinc; the word captured is fifo_rdata in the same cycle.
  - pop = m_valid & m_ready.
- Transitions:
  - EMPTY:
    - push → ONE, main<=rdata.
    - no push → stay EMPTY.
  - ONE:
    - push & pop → ONE, main<=rdata.
    - push only → TWO, skid<=rdata.
    - pop only → EMPTY.
    - neither → hold.
  - TWO (no push possible):
    - pop → ONE, main<=skid.
    - no pop → hold.
- Outputs:
  - m_valid = (state != EMPTY).
  - m_data changes only on a load into main and is stable while m_valid=1 and m_ready=0.
- Ordering: words leave in exactly FIFO order; no word is dropped or duplicated.
- m_ready while m_valid=0 has no effect.

## Timing
- Reset values: state=EMPTY, m_valid=0, m_data=0, skid=0, level=0, beat_cnt=0.
  - rinc=0 during reset, provided fifo_empty=1, which the upstream stage guarantees.
- Latency:
  - A word visible on fifo_rdata with fifo_empty=0 in cycle N appears on m_data with m_valid=1 in cycle N+1 when the buffer was EMPTY.
  - Minimum FIFO-to-stream latency is 1 rclk.
- Throughput: with m_ready held high and a non-empty FIFO, state stays ONE and one beat is accepted per cycle.
- Backpressure:
  - m_ready=0 from ONE absorbs at most one more word (→TWO), then rinc=0 until a pop.
  - After m_ready rises again, the next beat is the skid word in the following cycle.
- FIFO running empty: fifo_empty=1 forces rinc=0; the buffer drains normally.
- Reset mid-operation: buffered words are discarded and all outputs return immediately (asynchronously) to their reset values.

## Configuration
- FIFO_RD_STREAM_STATS_EN defined:
  - beat_cnt increments by 1 on each pop and wraps modulo 2^CNT_WIDTH.
  - It is reset to 0 by rst_n.
- FIFO_RD_STREAM_STATS_EN undefined:
  - The counter is not built and beat_cnt is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset check: assert rst_n=0 with fifo_empty=1 → m_valid=0, m_data=0, level=0, rinc=0, beat_cnt=0.
- Single word: FIFO holds 0xA5 and m_ready=1.
  - rinc=1 for one cycle.
  - Next cycle: m_valid=1, m_data=0xA5, level=1.
  - One cycle later: m_valid=0.
- Streaming: FIFO holds 0x01..0x08 and m_ready=1 throughout.
  - 8 consecutive beats 0x01..0x08, one per cycle.
  - level stays 1 until drained.
  - beat_cnt=8 (stats on) or 0 (stats off).
- Backpressure: FIFO holds 0x10..0x13 and m_ready=0.
  - level reaches 2 and rinc=0 thereafter.
  - m_data holds 0x10.
  - Releasing m_ready delivers 0x10, 0x11, 0x12, 0x13 in order with no loss.
- Alternating m_ready (1,0,1,0…) with a full FIFO → output sequence strictly in order, and m_data is stable during every m_ready=0 cycle.
- Mid-stream reset: pulse rst_n low while level=2 → all outputs go to reset values immediately, and after release the stream resumes from the FIFO's current head word.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter: turns the async FIFO's empty/rinc pop interface into a
// registered valid/ready stream with a 2-entry buffer. Optional beat counter: FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;

  assign m_valid = (state_q != ST_EMPTY);
  assign m_data  = main_q;
  assign level   = state_q;

  // rinc looks only at state and fifo_empty, so m_ready never reaches the FIFO combinationally.
  always_comb begin
    rinc    = ~fifo_empty & (state_q != ST_TWO);
    pop     = m_valid & m_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (rinc) begin
          state_d = ST_ONE;
          main_d  = fifo_rdata;
        end
      end
      ST_ONE: begin
        if (rinc && pop) begin
          main_d = fifo_rdata;
        end else if (rinc) begin
          state_d = ST_TWO;
          skid_d  = fifo_rdata;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream against a small FIFO model; expected values are hand-derived.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        rclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        rinc;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready = 1'b0;
  logic [1:0]  level;
  logic [15:0] beat_cnt;

  logic [7:0]  mem [0:63];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr = '0;

  int n_chk = 0;
  int n_err = 0;
  int exp_beats = 0;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rinc       (rinc),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .level      (level),
    .beat_cnt   (beat_cnt)
  );

  // Upstream read-pointer stage holds empty high while in reset.
  assign fifo_empty = ~rst_n | (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr];

  always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 6'd1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rst_n = 1'b0;
    @(negedge rclk);
    rst_n = 1'b1;
    exp_beats = 0;
  endtask

  function automatic logic [31:0] exp_cnt();
    return STATS ? 32'(exp_beats) : 32'd0;
  endfunction

  initial begin
    logic [7:0] held;
    logic       stall_prev;
    int         got;

    // Reset state
    repeat (2) @(negedge rclk);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_cnt", beat_cnt, 0);
    rst_n = 1'b1;

    // Single word
    @(negedge rclk);
    m_ready = 1'b1;
    push_word(8'hA5);
    #1 chk("single_rinc", rinc, 1);
    @(negedge rclk);
    chk("single_valid", m_valid, 1);
    chk("single_data", m_data, 8'hA5);
    chk("single_level", level, 1);
    chk("single_rinc_off", rinc, 0);
    exp_beats++;
    @(negedge rclk);
    chk("single_drain", m_valid, 0);
    chk("single_cnt", beat_cnt, exp_cnt());

    // Streaming at full rate
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    for (int i = 1; i <= 8; i++) begin
      @(negedge rclk);
      chk("stream_valid", m_valid, 1);
      chk("stream_data", m_data, 32'(i));
      chk("stream_level", level, 1);
      exp_beats++;
    end
    @(negedge rclk);
    chk("stream_drain", m_valid, 0);
    chk("stream_cnt", beat_cnt, exp_cnt());

    // Backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h10 + 8'(i));
    repeat (2) @(negedge rclk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_level", level, 2);
      chk("bp_rinc", rinc, 0);
      chk("bp_hold", m_data, 8'h10);
      @(negedge rclk);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", m_valid, 1);
      chk("bp_order", m_data, 8'h10 + 8'(k));
      exp_beats++;
      @(negedge rclk);
    end
    chk("bp_drain", m_valid, 0);
    chk("bp_cnt", beat_cnt, exp_cnt());

    // Alternating m_ready with a full FIFO
    for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
    got = 0;
    stall_prev = 1'b0;
    held = '0;
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge rclk);
      if (stall_prev) chk("alt_stable", m_data, held);
      m_ready = ~m_ready;
      stall_prev = 1'b0;
      if (m_valid && m_ready) begin
        chk("alt_order", m_data, 8'h30 + 8'(got));
        got++;
        exp_beats++;
      end else if (m_valid) begin
        held = m_data;
        stall_prev = 1'b1;
      end
    end
    chk("alt_count", got, 8);
    @(negedge rclk);
    m_ready = 1'b0;
    @(negedge rclk);
    chk("alt_cnt", beat_cnt, exp_cnt());

    // Mid-stream reset while two words are buffered
    for (int i = 0; i < 6; i++) push_word(8'h40 + 8'(i));
    repeat (3) @(negedge rclk);
    chk("mrst_pre_level", level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", m_valid, 0);
    chk("mrst_data", m_data, 0);
    chk("mrst_level", level, 0);
    chk("mrst_rinc", rinc, 0);
    chk("mrst_cnt", beat_cnt, 0);
    exp_beats = 0;
    @(negedge rclk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 2; k < 6; k++) begin
      @(negedge rclk);
      chk("mrst_valid_resume", m_valid, 1);
      chk("mrst_order", m_data, 8'h40 + 8'(k));
      exp_beats++;
    end
    @(negedge rclk);
    chk("mrst_drain", m_valid, 0);
    chk("mrst_final_cnt", beat_cnt, exp_cnt());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
